// File: rtl/ext_irq_ctrl_pkg.sv
// Shared definitions for the external interrupt controller: register map,
// reg-bus request/response types and small mask helpers.
package ext_irq_ctrl_pkg;

  localparam int unsigned MAX_SRC = 32;

  localparam logic [31:0] RAW_OFFSET      = 32'h00;
  localparam logic [31:0] PENDING_OFFSET  = 32'h04;
  localparam logic [31:0] ENABLE_OFFSET   = 32'h08;
  localparam logic [31:0] MODE_OFFSET     = 32'h0C;
  localparam logic [31:0] POLARITY_OFFSET = 32'h10;
  localparam logic [31:0] SWSET_OFFSET    = 32'h14;

  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        valid;
  } reg_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        error;
    logic        ready;
  } reg_rsp_t;

  // Register fields are held at full bus width; bits >= NUM_SRC stay 0.
  typedef struct packed {
    logic [MAX_SRC-1:0] pending;
    logic [MAX_SRC-1:0] enable;
    logic [MAX_SRC-1:0] mode;
    logic [MAX_SRC-1:0] polarity;
  } ext_irq_regs_t;

  // Mask with the low n bits set; safe for n == MAX_SRC.
  function automatic logic [MAX_SRC-1:0] src_mask(input int unsigned n);
    logic [MAX_SRC-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < MAX_SRC; i++) begin
      if (i < n) m[i] = 1'b1;
    end
    return m;
  endfunction

  // Expand byte strobes into a bit mask.
  function automatic logic [31:0] strb_mask(input logic [3:0] strb);
    return {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
  endfunction

endpackage

// File: rtl/ext_irq_sync.sv
// Per-bit synchroniser chain for raw interrupt sources. STAGES = 0 means the
// sources are already synchronous and are passed straight through.
module ext_irq_sync #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  if (STAGES == 0) begin : g_bypass
    assign q_o = d_i;
  end else begin : g_chain
    logic [STAGES-1:0][WIDTH-1:0] sync_q;

    // Shift each source through the flop chain; cleared on reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        sync_q <= '0;
      end else begin
        sync_q[0] <= d_i;
        for (int unsigned i = 1; i < STAGES; i++) begin
          sync_q[i] <= sync_q[i-1];
        end
      end
    end

    assign q_o = sync_q[STAGES-1];
  end

endmodule

// File: rtl/ext_irq_ctrl.sv
// Register-mapped external interrupt controller: synchronises sources,
// applies polarity and edge/level mode, latches sticky pending bits and
// drives registered, enable-masked interrupt lines to the core.
module ext_irq_ctrl
  import ext_irq_ctrl_pkg::*;
#(
  parameter int unsigned NUM_SRC     = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  reg_req_t           reg_req_i,
  output reg_rsp_t           reg_rsp_o,
  input  logic [NUM_SRC-1:0] src_i,
  output logic [NUM_SRC-1:0] irq_o,
  output logic               irq_any_o
);

  localparam logic [MAX_SRC-1:0] SRC_MASK = src_mask(NUM_SRC);

  logic [NUM_SRC-1:0] src_sync;
  logic [MAX_SRC-1:0] act;
  logic [MAX_SRC-1:0] act_q;
  ext_irq_regs_t      regs_q, regs_d;
  logic [NUM_SRC-1:0] irq_q, irq_d;
  logic               irq_any_q, irq_any_d;

  logic               addr_ok;
  logic               wr_en;
  logic [MAX_SRC-1:0] wr_mask;
  logic [MAX_SRC-1:0] wr_bits;
  logic [MAX_SRC-1:0] clr;
  logic [MAX_SRC-1:0] swset;
  logic [MAX_SRC-1:0] set_evt;
  logic [MAX_SRC-1:0] pend_en;

  ext_irq_sync #(
    .WIDTH  (NUM_SRC),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (src_i),
    .q_o   (src_sync)
  );

  // Active level of each source after polarity inversion.
  assign act = MAX_SRC'(src_sync) ^ regs_q.polarity;

  // Bus decode and combinational read response.
  always_comb begin
    addr_ok = (reg_req_i.addr[1:0] == 2'b00) && (reg_req_i.addr <= SWSET_OFFSET);
    wr_en   = reg_req_i.valid && reg_req_i.write && addr_ok;
    wr_mask = strb_mask(reg_req_i.wstrb) & SRC_MASK;
    wr_bits = reg_req_i.wdata & wr_mask;

    reg_rsp_o       = '0;
    reg_rsp_o.ready = reg_req_i.valid;
    reg_rsp_o.error = reg_req_i.valid && !addr_ok;
    if (reg_req_i.valid && !reg_req_i.write && addr_ok) begin
      case (reg_req_i.addr)
        RAW_OFFSET:      reg_rsp_o.rdata = act;
        PENDING_OFFSET:  reg_rsp_o.rdata = regs_q.pending;
        ENABLE_OFFSET:   reg_rsp_o.rdata = regs_q.enable;
        MODE_OFFSET:     reg_rsp_o.rdata = regs_q.mode;
        POLARITY_OFFSET: reg_rsp_o.rdata = regs_q.polarity;
        default:         reg_rsp_o.rdata = '0;
      endcase
    end
  end

  // Register writes, pending set/clear (set has priority) and output next-state.
  always_comb begin
    regs_d = regs_q;
    clr    = '0;
    swset  = '0;
    if (wr_en) begin
      case (reg_req_i.addr)
        PENDING_OFFSET:  clr = wr_bits;
        ENABLE_OFFSET:   regs_d.enable   = (regs_q.enable   & ~wr_mask) | wr_bits;
        MODE_OFFSET:     regs_d.mode     = (regs_q.mode     & ~wr_mask) | wr_bits;
        POLARITY_OFFSET: regs_d.polarity = (regs_q.polarity & ~wr_mask) | wr_bits;
        SWSET_OFFSET:    swset = wr_bits;
        default:         ;
      endcase
    end

    set_evt        = (regs_q.mode & act & ~act_q) | (~regs_q.mode & act) | swset;
    regs_d.pending = (regs_q.pending & ~clr) | set_evt;

    pend_en   = regs_q.pending & regs_q.enable;
    irq_d     = pend_en[NUM_SRC-1:0];
    irq_any_d = |pend_en;
  end

  // State registers: configuration, pending, edge history and output flops.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      regs_q    <= '0;
      act_q     <= '0;
      irq_q     <= '0;
      irq_any_q <= 1'b0;
    end else begin
      regs_q    <= regs_d;
      act_q     <= act;
      irq_q     <= irq_d;
      irq_any_q <= irq_any_d;
    end
  end

  assign irq_o     = irq_q;
  assign irq_any_o = irq_any_q;

endmodule
